// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage access unit and the memory system.
// The unit drives the request side (req/we/addr/be/wdata); the memory side
// answers with gnt (request accepted) and rvalid/rdata (response).
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit. Non-memory results flow straight through to MEM/WB.
// Loads and stores are issued on a req/gnt/rvalid bus, with stall_o holding
// the upstream stages until the response arrives, the access is rejected as
// misaligned/illegal, or the timeout counter gives up on it.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              rd_addr_i,
    input  logic [31:0]             rd_data_i,
    input  logic                    rd_wen_i,
    input  logic                    mem_re_i,
    input  logic                    mem_we_i,
    input  logic [2:0]              funct3_i,
    input  logic [31:0]             store_data_i,
    output logic [4:0]              rd_addr_o,
    output logic [31:0]             rd_data_o,
    output logic                    rd_wen_o,
    output logic                    stall_o,
    output logic                    mem_err_o,
    output logic                    timeout_o,
    mem_access_unit_if.master       dbus
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t     state;
    logic [7:0] tmo_cnt;

    logic [1:0] lane;
    logic       is_mem;
    logic       legal;
    logic       access_ok;
    logic       done;
    logic       expire;

    // Legality of an access: supported funct3 for its direction and natural
    // alignment for halves and words. Bytes are always aligned.
    function automatic logic legal_access(input logic       re,
                                          input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        if (re) begin
            case (f3)
                F3_B, F3_BU: ok = 1'b1;
                F3_H, F3_HU: ok = ~a[0];
                F3_W:        ok = (a == 2'b00);
                default:     ok = 1'b0;
            endcase
        end else if (we) begin
            case (f3)
                F3_B:    ok = 1'b1;
                F3_H:    ok = ~a[0];
                F3_W:    ok = (a == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Select the addressed byte/half of the read word and sign/zero extend.
    function automatic logic [31:0] load_align(input logic [2:0]  f3,
                                               input logic [1:0]  a,
                                               input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'b0, b};
            F3_HU:   r = {16'b0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Byte enables for a store of the given size at the given lane.
    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << a;
            F3_H:    be = a[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane it could land in.
    function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                                input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {4{d[7:0]}};
            F3_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    assign lane      = rd_data_i[1:0];
    assign is_mem    = mem_re_i | mem_we_i;
    assign legal     = legal_access(mem_re_i, mem_we_i, funct3_i, lane);
    assign access_ok = is_mem & legal;

    // A response only completes an access once the request has been granted;
    // completion takes priority over a coincident timeout.
    assign done   = (state == S_WAIT) & dbus.rvalid;
    assign expire = (state != S_IDLE) & ~done & (tmo_cnt == TMO_LAST);

    // Request attributes come straight from EX/MEM, which holds them stable
    // for the whole access.
    always_comb begin
        dbus.we    = mem_we_i;
        dbus.addr  = {rd_data_i[31:2], 2'b00};
        dbus.be    = mem_we_i ? store_be(funct3_i, lane) : 4'b1111;
        dbus.wdata = store_data_i;
        if (mem_we_i) begin
            dbus.wdata = store_wdata(funct3_i, store_data_i);
        end
    end

    // Output decode: pass-through, request/stall, completion and error pulses.
    always_comb begin
        dbus.req  = 1'b0;
        stall_o   = 1'b0;
        rd_wen_o  = 1'b0;
        mem_err_o = 1'b0;
        timeout_o = 1'b0;
        rd_addr_o = rd_addr_i;
        rd_data_o = rd_data_i;
        if (rst) begin
            rd_addr_o = 5'd0;
            rd_data_o = 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!is_mem) begin
                        rd_wen_o = rd_wen_i;
                    end else if (!legal) begin
                        mem_err_o = 1'b1;
                    end else begin
                        dbus.req = 1'b1;
                        stall_o  = 1'b1;
                    end
                end
                S_REQ: begin
                    // An abandoned request is withdrawn so no grant is taken.
                    if (expire) begin
                        timeout_o = 1'b1;
                    end else begin
                        dbus.req = 1'b1;
                        stall_o  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        if (mem_re_i) begin
                            rd_data_o = load_align(funct3_i, lane, dbus.rdata);
                            rd_wen_o  = rd_wen_i;
                        end
                    end else if (expire) begin
                        timeout_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                default: begin
                    rd_wen_o = 1'b0;
                end
            endcase
        end
    end

    // Access sequencer and timeout counter; responses seen in IDLE are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tmo_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access_ok) begin
                        tmo_cnt <= 8'd0;
                        state   <= dbus.gnt ? S_WAIT : S_REQ;
                    end
                end
                S_REQ: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (expire) begin
                        state <= S_IDLE;
                    end else if (dbus.gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (done || expire) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, byte/half loads,
// half/byte stores, misalignment, timeout and reset in the middle of an access.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_wen_i;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [2:0]  funct3_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        stall_o;
    logic        mem_err_o;
    logic        timeout_o;

    int total;
    int bad;

    mem_access_unit_if dbus ();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr_i    (rd_addr_i),
        .rd_data_i    (rd_data_i),
        .rd_wen_i     (rd_wen_i),
        .mem_re_i     (mem_re_i),
        .mem_we_i     (mem_we_i),
        .funct3_i     (funct3_i),
        .store_data_i (store_data_i),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .rd_wen_o     (rd_wen_o),
        .stall_o      (stall_o),
        .mem_err_o    (mem_err_o),
        .timeout_o    (timeout_o),
        .dbus         (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic re, input logic we, input logic [2:0] f3,
                          input logic [4:0] ra, input logic [31:0] rdv,
                          input logic wen, input logic [31:0] sd);
        mem_re_i     = re;
        mem_we_i     = we;
        funct3_i     = f3;
        rd_addr_i    = ra;
        rd_data_i    = rdv;
        rd_wen_i     = wen;
        store_data_i = sd;
    endtask

    task automatic set_bus(input logic g, input logic rv, input logic [31:0] rd);
        dbus.gnt    = g;
        dbus.rvalid = rv;
        dbus.rdata  = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;

        // Reset with a legal load presented: everything held quiet.
        rst = 1'b1;
        set_op(1'b1, 1'b0, 3'b010, 5'd7, 32'h0000_0100, 1'b1, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req",   32'(dbus.req), 32'd0);
        chk("rst_wen",   32'(rd_wen_o), 32'd0);
        chk("rst_addr",  32'(rd_addr_o), 32'd0);
        chk("rst_data",  rd_data_o, 32'd0);
        chk("rst_err",   32'(mem_err_o), 32'd0);

        // ALU op passes straight through.
        step();
        rst = 1'b0;
        set_op(1'b0, 1'b0, 3'b000, 5'd5, 32'h0000_1234, 1'b1, 32'h0);
        @(negedge clk);
        chk("alu_addr",  32'(rd_addr_o), 32'd5);
        chk("alu_data",  rd_data_o, 32'h0000_1234);
        chk("alu_wen",   32'(rd_wen_o), 32'd1);
        chk("alu_stall", 32'(stall_o), 32'd0);
        chk("alu_req",   32'(dbus.req), 32'd0);

        // LB at 0x103: grant at t0, response at t2.
        step();
        set_op(1'b1, 1'b0, 3'b000, 5'd3, 32'h0000_0103, 1'b1, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("lb_t0_req",   32'(dbus.req), 32'd1);
        chk("lb_t0_stall", 32'(stall_o), 32'd1);
        chk("lb_t0_wen",   32'(rd_wen_o), 32'd0);
        chk("lb_t0_addr",  dbus.addr, 32'h0000_0100);
        chk("lb_t0_we",    32'(dbus.we), 32'd0);
        step();
        set_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lb_t1_stall", 32'(stall_o), 32'd1);
        chk("lb_t1_req",   32'(dbus.req), 32'd0);
        chk("lb_t1_wen",   32'(rd_wen_o), 32'd0);
        step();
        set_bus(1'b0, 1'b1, 32'h80FF_FF00);
        @(negedge clk);
        chk("lb_t2_stall", 32'(stall_o), 32'd0);
        chk("lb_t2_data",  rd_data_o, 32'hFFFF_FF80);
        chk("lb_t2_wen",   32'(rd_wen_o), 32'd1);

        // SH at 0x202: grant delayed three cycles, ack in the following cycle.
        step();
        set_op(1'b0, 1'b1, 3'b001, 5'd6, 32'h0000_0202, 1'b1, 32'h0000_ABCD);
        set_bus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dbus.gnt = 1'b1;
            @(negedge clk);
            chk($sformatf("sh_t%0d_req", i),   32'(dbus.req), 32'd1);
            chk($sformatf("sh_t%0d_stall", i), 32'(stall_o), 32'd1);
            chk($sformatf("sh_t%0d_be", i),    32'(dbus.be), 32'h0000_000C);
            chk($sformatf("sh_t%0d_wdata", i), dbus.wdata, 32'hABCD_ABCD);
            chk($sformatf("sh_t%0d_addr", i),  dbus.addr, 32'h0000_0200);
            chk($sformatf("sh_t%0d_we", i),    32'(dbus.we), 32'd1);
            step();
        end
        set_bus(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("sh_ack_req",   32'(dbus.req), 32'd0);
        chk("sh_ack_stall", 32'(stall_o), 32'd0);
        chk("sh_ack_wen",   32'(rd_wen_o), 32'd0);
        chk("sh_ack_tmo",   32'(timeout_o), 32'd0);

        // Misaligned LW: error pulse only.
        step();
        set_op(1'b1, 1'b0, 3'b010, 5'd8, 32'h0000_0101, 1'b1, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lwmis_err",   32'(mem_err_o), 32'd1);
        chk("lwmis_req",   32'(dbus.req), 32'd0);
        chk("lwmis_wen",   32'(rd_wen_o), 32'd0);
        chk("lwmis_stall", 32'(stall_o), 32'd0);

        // LHU at 0x102: upper half, zero extended.
        step();
        set_op(1'b1, 1'b0, 3'b101, 5'd4, 32'h0000_0102, 1'b1, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("lhu_t0_err", 32'(mem_err_o), 32'd0);
        chk("lhu_t0_req", 32'(dbus.req), 32'd1);
        step();
        set_bus(1'b0, 1'b1, 32'h8001_7FFF);
        @(negedge clk);
        chk("lhu_data",  rd_data_o, 32'h0000_8001);
        chk("lhu_wen",   32'(rd_wen_o), 32'd1);
        chk("lhu_addr",  32'(rd_addr_o), 32'd4);
        chk("lhu_stall", 32'(stall_o), 32'd0);

        // SB at 0x301: lane 1.
        step();
        set_op(1'b0, 1'b1, 3'b000, 5'd2, 32'h0000_0301, 1'b0, 32'h1234_565A);
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("sb_be",    32'(dbus.be), 32'h0000_0002);
        chk("sb_wdata", dbus.wdata, 32'h5A5A_5A5A);
        chk("sb_addr",  dbus.addr, 32'h0000_0300);
        step();
        set_bus(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("sb_ack_stall", 32'(stall_o), 32'd0);
        chk("sb_ack_wen",   32'(rd_wen_o), 32'd0);

        // Timeout: LW granted, no response; abandoned in the 4th REQ/WAIT cycle.
        step();
        set_op(1'b1, 1'b0, 3'b010, 5'd10, 32'h0000_0400, 1'b1, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("tmo_t0_req", 32'(dbus.req), 32'd1);
        step();
        set_bus(1'b0, 1'b0, 32'h0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("tmo_t%0d_stall", i), 32'(stall_o), 32'd1);
            chk($sformatf("tmo_t%0d_pulse", i), 32'(timeout_o), 32'd0);
            step();
        end
        @(negedge clk);
        chk("tmo_t4_pulse", 32'(timeout_o), 32'd1);
        chk("tmo_t4_stall", 32'(stall_o), 32'd0);
        chk("tmo_t4_wen",   32'(rd_wen_o), 32'd0);
        chk("tmo_t4_req",   32'(dbus.req), 32'd0);
        step();
        set_op(1'b0, 1'b0, 3'b000, 5'd9, 32'h0000_0055, 1'b1, 32'h0);
        set_bus(1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("late_addr",  32'(rd_addr_o), 32'd9);
        chk("late_data",  rd_data_o, 32'h0000_0055);
        chk("late_wen",   32'(rd_wen_o), 32'd1);
        chk("late_stall", 32'(stall_o), 32'd0);
        chk("late_tmo",   32'(timeout_o), 32'd0);

        // Reset while waiting for a response; the response is dropped.
        step();
        set_op(1'b1, 1'b0, 3'b010, 5'd11, 32'h0000_0500, 1'b1, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("rstw_t0_req", 32'(dbus.req), 32'd1);
        step();
        rst = 1'b1;
        set_bus(1'b0, 1'b1, 32'h1234_5678);
        @(negedge clk);
        chk("rstw_stall", 32'(stall_o), 32'd0);
        chk("rstw_wen",   32'(rd_wen_o), 32'd0);
        chk("rstw_data",  rd_data_o, 32'd0);
        chk("rstw_req",   32'(dbus.req), 32'd0);
        step();
        rst = 1'b0;
        set_bus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rstw_idle_req",   32'(dbus.req), 32'd1);
        chk("rstw_idle_stall", 32'(stall_o), 32'd1);
        chk("rstw_idle_wen",   32'(rd_wen_o), 32'd0);
        step();
        rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
